div_seq_ctrl: RTL



---
 rtl/div_seq_ctrl_if.sv | 24 ++
 rtl/div_seq_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl_if.sv
// Issue/result bundle between the divide issuer and div_seq_ctrl.
// The master drives operands and start; the slave returns status and results.
interface div_seq_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider: one (WIDTH+1)-cell ripple-borrow row reused over WIDTH cycles.
// Optional macro DIVCTL_SIGNED_EN selects two's-complement operands (magnitude divide plus sign fix-up).
module div_seq_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    div_seq_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef DIVCTL_SIGNED_EN
    logic             sq_q, sq_d;
    logic             sr_q, sr_d;
`endif

    logic [WIDTH:0]   row_trial;
    logic [WIDTH:0]   row_sub;
    logic [WIDTH:0]   row_diff;
    logic             row_borrow;
    logic             row_ctrl;
    logic [WIDTH:0]   r_new;
    logic [WIDTH-1:0] q_new;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quo_fin;
    logic [WIDTH-1:0] rem_fin;

    assign row_trial = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign row_sub   = {1'b0, d_q};

    // Ripple-borrow full-subtractor row; final borrow selects restore vs. difference.
    always_comb begin : ripple_row
        logic bw;
        bw       = 1'b0;
        row_diff = '0;
        for (int unsigned i = 0; i <= WIDTH; i++) begin
            row_diff[i] = row_trial[i] ^ row_sub[i] ^ bw;
            bw = (~row_trial[i] & row_sub[i]) | (~(row_trial[i] ^ row_sub[i]) & bw);
        end
        row_borrow = bw;
    end

    assign row_ctrl = ~row_borrow;
    assign r_new    = row_ctrl ? row_diff : row_trial;
    assign q_new    = {q_q[WIDTH-2:0], row_ctrl};

`ifdef DIVCTL_SIGNED_EN
    assign dvd_mag = bus.dividend[WIDTH-1] ? WIDTH'(~bus.dividend + 1'b1) : bus.dividend;
    assign dvs_mag = bus.divisor[WIDTH-1]  ? WIDTH'(~bus.divisor + 1'b1)  : bus.divisor;
    assign quo_fin = sq_q ? WIDTH'(~q_new + 1'b1) : q_new;
    assign rem_fin = sr_q ? WIDTH'(~r_new[WIDTH-1:0] + 1'b1) : r_new[WIDTH-1:0];
`else
    assign dvd_mag = bus.dividend;
    assign dvs_mag = bus.divisor;
    assign quo_fin = q_new;
    assign rem_fin = r_new[WIDTH-1:0];
`endif

    // Next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef DIVCTL_SIGNED_EN
        sq_d    = sq_q;
        sr_d    = sr_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        state_d = S_DONE;
                        quo_d   = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        d_d     = dvs_mag;
                        q_d     = dvd_mag;
                        r_d     = '0;
                        cnt_d   = CW'(WIDTH - 1);
`ifdef DIVCTL_SIGNED_EN
                        sq_d    = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        sr_d    = bus.dividend[WIDTH-1];
`endif
                    end
                end
            end
            S_RUN: begin
                r_d   = r_new;
                q_d   = q_new;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    quo_d   = quo_fin;
                    rem_d   = rem_fin;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            d_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIVCTL_SIGNED_EN
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DIVCTL_SIGNED_EN
            sq_q    <= sq_d;
            sr_q    <= sr_d;
`endif
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule
